// File: rtl/uart_pkg.sv
// uart_pkg: shared UART types and baud helper (parity modes, tx FSM states, clks_per_bit)
package uart_pkg;
  typedef enum logic [1:0] {PAR_NONE, PAR_ODD, PAR_EVEN} parity_t;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} tx_state_t;
  function automatic int clks_per_bit(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction
endpackage

// File: rtl/uart_baud_gen.sv
// uart_baud_gen: baud counter 0..CLKS_PER_BIT-1 with one-cycle tick at terminal count; ports clk, rst (async), clr (sync clear), tick
module uart_baud_gen #(
  parameter int CLKS_PER_BIT = 104
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);
  localparam int W = $clog2(CLKS_PER_BIT);
  localparam logic [W-1:0] LAST = W'(CLKS_PER_BIT - 1);
  logic [W-1:0] cnt;
  assign tick = cnt == LAST;
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt <= '0;
    else cnt <= (clr || tick) ? '0 : cnt + 1'b1;
endmodule

// File: rtl/uart_tx_cfg.sv
// uart_tx_cfg: parametrised LSB-first UART transmitter; ports clk, rst (async), tx_valid/tx_data/tx_ready handshake, tx line, tx_busy, tx_done pulse
module uart_tx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ    = 1000000,
  parameter int BAUD_RATE   = 9600,
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tx_valid,
  input  logic [DATA_BITS-1:0] tx_data,
  output logic                 tx_ready,
  output logic                 tx,
  output logic                 tx_busy,
  output logic                 tx_done
);
  localparam int CPB = clks_per_bit(CLK_FREQ, BAUD_RATE);
  localparam bit PAR_EN = PARITY_MODE != int'(PAR_NONE);
  localparam int BW = $clog2(DATA_BITS + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);
  localparam logic [BW-1:0] LAST_STOP = BW'(STOP_BITS - 1);
  if (CPB < 2) begin : g_bad_cpb
    $error("uart_tx_cfg: CLK_FREQ/BAUD_RATE must be at least 2");
  end
  if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data
    $error("uart_tx_cfg: DATA_BITS must be 5..9");
  end
  if (PARITY_MODE < 0 || PARITY_MODE > 2) begin : g_bad_par
    $error("uart_tx_cfg: PARITY_MODE must be 0, 1 or 2");
  end
  if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop
    $error("uart_tx_cfg: STOP_BITS must be 1 or 2");
  end
  tx_state_t state;
  logic [DATA_BITS-1:0] shreg;
  logic [BW-1:0] bit_cnt;
  logic par, par_q, tick;
  assign par = (^tx_data) ^ (PARITY_MODE == int'(PAR_ODD));
  assign tx_ready = (state == IDLE) && !rst;
  uart_baud_gen #(.CLKS_PER_BIT(CPB)) u_baud (
    .clk (clk),
    .rst (rst),
    .clr (state == IDLE),
    .tick(tick)
  );
  // Data leaves through a right-shifting copy of the latched word, so the
  // line always takes bit 0 and input changes while busy cannot reach it.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      tx_busy <= 1'b0;
      tx_done <= 1'b0;
      bit_cnt <= '0;
      shreg   <= '0;
      par_q   <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      case (state)
        IDLE: if (tx_valid) begin
          shreg   <= tx_data;
          par_q   <= par;
          bit_cnt <= '0;
          tx      <= 1'b0;
          tx_busy <= 1'b1;
          state   <= START;
        end
        START: if (tick) begin
          tx    <= shreg[0];
          shreg <= shreg >> 1;
          state <= DATA;
        end
        DATA: if (tick) begin
          if (bit_cnt == LAST_BIT) begin
            bit_cnt <= '0;
            tx      <= PAR_EN ? par_q : 1'b1;
            state   <= PAR_EN ? PARITY : STOP;
          end else begin
            bit_cnt <= bit_cnt + 1'b1;
            tx      <= shreg[0];
            shreg   <= shreg >> 1;
          end
        end
        PARITY: if (tick) begin
          tx    <= 1'b1;
          state <= STOP;
        end
        STOP: if (tick) begin
          if (bit_cnt == LAST_STOP) begin
            bit_cnt <= '0;
            tx_busy <= 1'b0;
            tx_done <= 1'b1;
            state   <= IDLE;
          end else bit_cnt <= bit_cnt + 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
endmodule

// File: tb/tb_uart_tx_cfg.sv
// tb_uart_tx_cfg: directed self-checking bench for uart_tx_cfg across 8N1, 8E1, 8O1, 7O2 and 8N2 configurations
module tb_uart_tx_cfg;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic valid [5];
  logic [8:0] data [5];
  logic txl [5];
  logic busy [5];
  logic done [5];
  logic ready [5];
  int n_assert = 0;
  int n_fail = 0;
  always #5 clk = ~clk;
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tx_valid(valid[0]), .tx_data(data[0][7:0]),
    .tx_ready(ready[0]), .tx(txl[0]), .tx_busy(busy[0]), .tx_done(done[0]));
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY_MODE(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .tx_valid(valid[1]), .tx_data(data[1][7:0]),
    .tx_ready(ready[1]), .tx(txl[1]), .tx_busy(busy[1]), .tx_done(done[1]));
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .tx_valid(valid[2]), .tx_data(data[2][7:0]),
    .tx_ready(ready[2]), .tx(txl[2]), .tx_busy(busy[2]), .tx_done(done[2]));
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(7), .PARITY_MODE(1), .STOP_BITS(2)) u_7o2 (
    .clk(clk), .rst(rst), .tx_valid(valid[3]), .tx_data(data[3][6:0]),
    .tx_ready(ready[3]), .tx(txl[3]), .tx_busy(busy[3]), .tx_done(done[3]));
  uart_tx_cfg #(.CLK_FREQ(1000000), .BAUD_RATE(100000), .DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(2)) u_8n2 (
    .clk(clk), .rst(rst), .tx_valid(valid[4]), .tx_data(data[4][7:0]),
    .tx_ready(ready[4]), .tx(txl[4]), .tx_busy(busy[4]), .tx_done(done[4]));
  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  // bits holds the hand-computed line sequence, bit j = j-th bit time after acceptance
  task automatic run_frame(input int k, input logic [8:0] d, input logic [11:0] bits, input int len,
                           input bit hold, input bit glitch, input logic [8:0] nd);
    valid[k] = 1'b1;
    data[k] = d;
    step();
    valid[k] = hold;
    data[k] = nd;
    for (int c = 0; c <= len; c++) begin
      chk($sformatf("u%0d d%0h tx c%0d", k, d, c), 16'(txl[k]), 16'(c < len ? bits[c / 10] : 1'b1));
      chk($sformatf("u%0d d%0h busy c%0d", k, d, c), 16'(busy[k]), 16'(c < len));
      chk($sformatf("u%0d d%0h done c%0d", k, d, c), 16'(done[k]), 16'(c == len));
      chk($sformatf("u%0d d%0h ready c%0d", k, d, c), 16'(ready[k]), 16'(c == len));
      if (glitch) begin
        valid[k] = (c == 30);
        data[k] = (c == 30) ? 9'h03C : nd;
      end
      if (c < len) step();
    end
  endtask
  initial begin
    for (int k = 0; k < 5; k++) begin
      valid[k] = 1'b0;
      data[k] = '0;
    end
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    step();
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("reset tx u%0d", k), 16'(txl[k]), 16'h1);
      chk($sformatf("reset busy u%0d", k), 16'(busy[k]), 16'h0);
      chk($sformatf("reset done u%0d", k), 16'(done[k]), 16'h0);
      chk($sformatf("reset ready u%0d", k), 16'(ready[k]), 16'h1);
    end
    run_frame(0, 9'h0A5, 12'h34A, 100, 1'b0, 1'b0, 9'h0A5);
    run_frame(1, 9'h007, 12'h60E, 110, 1'b0, 1'b0, 9'h007);
    run_frame(2, 9'h007, 12'h40E, 110, 1'b0, 1'b0, 9'h007);
    run_frame(3, 9'h07F, 12'h6FE, 110, 1'b0, 1'b0, 9'h07F);
    run_frame(4, 9'h000, 12'h600, 110, 1'b1, 1'b0, 9'h0FF);
    run_frame(4, 9'h0FF, 12'h7FE, 110, 1'b0, 1'b0, 9'h0FF);
    run_frame(0, 9'h081, 12'h302, 100, 1'b0, 1'b1, 9'h081);
    valid[0] = 1'b1;
    data[0] = 9'h05A;
    step();
    valid[0] = 1'b0;
    repeat (35) step();
    chk("midframe tx c35", 16'(txl[0]), 16'h0);
    chk("midframe busy c35", 16'(busy[0]), 16'h1);
    #2 rst = 1'b1;
    #1;
    chk("async rst tx", 16'(txl[0]), 16'h1);
    chk("async rst busy", 16'(busy[0]), 16'h0);
    chk("async rst done", 16'(done[0]), 16'h0);
    chk("async rst ready", 16'(ready[0]), 16'h0);
    step();
    step();
    rst = 1'b0;
    for (int c = 0; c < 120; c++) begin
      step();
      chk($sformatf("post rst done c%0d", c), 16'(done[0]), 16'h0);
      chk($sformatf("post rst tx c%0d", c), 16'(txl[0]), 16'h1);
      chk($sformatf("post rst ready c%0d", c), 16'(ready[0]), 16'h1);
    end
    run_frame(0, 9'h0A5, 12'h34A, 100, 1'b0, 1'b0, 9'h0A5);
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
